booth_r4_mult_pipe: RTL and testbench
=====================================

// Module: booth_r4_mult_pipe
// PURPOSE
//  Parametrised, pipelined radix-4 Booth multiplier for the FIR datapath (tap-coefficient x sample).
//  Successor to the combinational 64-bit Booth array: width is generic, signed/unsigned is selectable
//  per operation, and it adds valid/ready handshakes, a pass-through tag and a fixed 3-stage pipeline.
//  Sits between the coefficient/sample fetch logic and the FIR accumulator.
// PARAMETERS
//  WIDTH   64  operand width in bits; even, >= 4
//  TAG_W   8   width of the sideband tag carried alongside each operation (>= 1)
//  GRP     4   partial products summed per group in stage 2; >= 2
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          block can accept; transfer when in_valid && in_ready
//  in_a       in   WIDTH      multiplicand
//  in_b       in   WIDTH      multiplier (Booth-recoded)
//  in_signed  in   1          1: both operands two's complement; 0: both unsigned
//  in_tag     in   TAG_W      sideband, returned unchanged with the result
//  out_valid  out  1          product valid
//  out_ready  in   1          consumer accepts; transfer when out_valid && out_ready
//  out_prod   out  2*WIDTH    exact product (signed or unsigned per captured in_signed)
//  out_tag    out  TAG_W      tag of this product
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids 0; out_valid=0, out_prod=0, out_tag=0; in_ready=1.
//  Pipeline: S1 captures a, b, signed, tag; S2 recodes, selects PPs, sums groups of GRP; S3 final sum -> outputs.
//  Latency: op accepted at edge N -> out_valid=1 with result after edge N+2. Throughput: 1 op/cycle.
//  Stall: adv = !out_valid || out_ready. All stages advance together when adv=1, hold when adv=0.
//  in_ready = adv (combinational from out_ready; no combinational path in_valid->in_ready).
//  Bubbles advance as invalid stages; out_valid stays high, out_prod/out_tag stable while !out_ready.
//  Simultaneous accept and output transfer in one cycle is legal and must not lose or duplicate an op.
//  Reset mid-operation: all in-flight ops discarded; no out_valid until a new op is accepted.
//  Operand extension: a_ext = WIDTH+2 bits, b_ext = WIDTH+2 bits, sign-extended if signed else zero-extended;
//   b_ext[-1]=0. Digits NDIG = WIDTH/2+1; digit i from b_ext[2i+1:2i-1].
//  Booth map {b2,b1,b0}: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
//  PP i = digit*a_ext, sign-extended to 2*WIDTH+2 bits, weighted 4^i; all sums modulo 2^(2*WIDTH+2),
//   out_prod = low 2*WIDTH bits. Negation = invert + 1 (the +1 may be injected as a correction bit).
//  Group sums: ceil(NDIG/GRP) registered in S2; last group zero-padded.
//  Result exact for full range: signed min*min = 2^(2*WIDTH-2); unsigned max*max = (2^WIDTH-1)^2.
//  Signed/unsigned may change every op; each op uses its own captured in_signed.
//  out_tag = in_tag of the same op; order preserved (strict FIFO order, no reordering).
// STRUCTURE
//  Package booth_r4_pkg: Booth digit enum (ZERO, POS1, POS2, NEG2, NEG1), function
//   booth_digit(3-bit) -> enum, localparam-derived NDIG/NGRP helpers.
//  Sub-module booth_r4_pp_sel: one digit's 3-bit window + a_ext -> signed PP (2*WIDTH+2 bits);
//   instantiated NDIG times via generate. Adder trees and pipeline registers live in the top.
//  No vendor primitives; plain '+' allowed for group and final sums.
// TESTING
//  WIDTH=64 signed: a=-1, b=-1 -> out_prod=1; a=b=0x8000_0000_0000_0000 -> 0x4000..0 (2^126).
//  WIDTH=64 unsigned: a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  Back-to-back: 8 ops on consecutive cycles, out_ready=1 -> 8 results on 8 consecutive cycles,
//   first after edge N+2, tags 0..7 in order.
//  Backpressure: out_ready=0 for 5 cycles with 3 ops in flight -> in_ready=0, out_prod/out_tag held,
//   no loss/duplication after release.
//  Reset pulse (rst_n=0 for 1 cycle, asynchronous, mid-clock) with 2 ops in flight -> out_valid=0 at once;
//   next result is that of the first op after reset.
//  Random: 10k ops, WIDTH in {4,16,64}, random in_signed, random in_valid/out_ready gaps
//   -> every out_prod matches reference a*b with correct signedness; scoreboard on tag order.

Source files
------------

// File: rtl/booth_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier pipeline.
package booth_r4_pkg;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } booth_digit_e;

  // Map a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]} to its Booth digit.
  function automatic booth_digit_e booth_digit(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // Radix-4 digits needed for a width-bit operand extended by two bits.
  function automatic int ndig(input int width);
    return width / 2 + 1;
  endfunction

  // Number of stage-2 groups; the last one is zero-padded.
  function automatic int ngrp(input int nd, input int grp);
    return (nd + grp - 1) / grp;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// One Booth digit: select digit * a_ext as a sign-extended partial product.
module booth_r4_pp_sel
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [2:0]         win,
  input  logic [WIDTH+1:0]   a_ext,
  output logic [2*WIDTH+1:0] pp
);

  localparam int PW = 2 * WIDTH + 2;

  logic [PW-1:0] a_sx;
  logic [PW-1:0] a_x2;

  assign a_sx = {{WIDTH{a_ext[WIDTH+1]}}, a_ext};
  assign a_x2 = a_sx << 1;

  // Multiple select; negation is invert plus one, all modulo 2^PW.
  always_comb begin
    pp = '0;
    case (booth_digit(win))
      POS1:    pp = a_sx;
      POS2:    pp = a_x2;
      NEG1:    pp = ~a_sx + PW'(1);
      NEG2:    pp = ~a_x2 + PW'(1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_pipe.sv
// Three-stage radix-4 Booth multiplier with valid/ready handshakes and a tag.
// S1: operand capture, S2: recode + grouped partial-product sums, S3: final sum.
module booth_r4_mult_pipe
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8,
  parameter int GRP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NDIG   = ndig(WIDTH);
  localparam int NGRP   = ngrp(NDIG, GRP);
  localparam int PW     = 2 * WIDTH + 2;
  localparam int STAGES = 2;

  typedef logic [2*WIDTH-1:0] prod_t;

  logic [STAGES:0]    vld_pipe;
  logic               adv;

  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic               s1_sgn;
  logic [TAG_W-1:0]   s1_tag;

  logic [PW-1:0]      s2_grp [NGRP];
  logic [TAG_W-1:0]   s2_tag;

  logic [WIDTH+1:0]   a_ext;
  logic [WIDTH+2:0]   b_win;
  logic [PW-1:0]      ppw [NGRP*GRP];
  logic [PW-1:0]      grp_sum [NGRP];
  logic [PW-1:0]      fin_sum;

  // Whole pipe moves as one; the output register only blocks when it holds an unaccepted product.
  assign adv       = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // Extend by two bits so both signed and unsigned operands fit the signed Booth recoding.
  assign a_ext = {{2{s1_sgn & s1_a[WIDTH-1]}}, s1_a};
  assign b_win = {{2{s1_sgn & s1_b[WIDTH-1]}}, s1_b, 1'b0};

  for (genvar i = 0; i < NGRP * GRP; i++) begin : g_pp
    if (i < NDIG) begin : g_dig
      logic [PW-1:0] pp;
      booth_r4_pp_sel #(.WIDTH(WIDTH)) u_sel (
        .win   (b_win[2*i+2 -: 3]),
        .a_ext (a_ext),
        .pp    (pp)
      );
      assign ppw[i] = pp << (2 * i);
    end else begin : g_pad
      assign ppw[i] = '0;
    end
  end

  // Stage-2 group sums of weighted partial products.
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_sum[g] = '0;
      for (int k = 0; k < GRP; k++) grp_sum[g] = grp_sum[g] + ppw[g*GRP+k];
    end
  end

  // Stage-3 final sum of the registered groups.
  always_comb begin
    fin_sum = '0;
    for (int g = 0; g < NGRP; g++) fin_sum = fin_sum + s2_grp[g];
  end

  // Pipeline registers: all stages load together on adv, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sgn   <= 1'b0;
      s1_tag   <= '0;
      for (int g = 0; g < NGRP; g++) s2_grp[g] <= '0;
      s2_tag   <= '0;
      out_prod <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_sgn   <= in_signed;
      s1_tag   <= in_tag;
      s2_grp   <= grp_sum;
      s2_tag   <= s1_tag;
      out_prod <= prod_t'(fin_sum);
      out_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_booth_r4_mult_pipe.sv
// Self-checking bench: directed corners/latency/stall/reset on WIDTH=64 and a
// randomized handshake run on WIDTH 4, 16 and 64 against a plain-arithmetic model.
module tb_booth_r4_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_signed = 1'b0;
  logic [63:0]  in_a = '0;
  logic [63:0]  in_b = '0;
  logic [7:0]   in_tag = '0;
  int           sel = 2;

  logic         in_ready, out_valid;
  logic [127:0] out_prod;
  logic [7:0]   out_tag;

  logic v4, r4, ov4, v16, r16, ov16, v64, r64, ov64;
  logic [7:0]   p4, t4, t16, t64;
  logic [31:0]  p16;
  logic [127:0] p64;

  assign v4  = in_valid && (sel == 0);
  assign v16 = in_valid && (sel == 1);
  assign v64 = in_valid && (sel == 2);

  booth_r4_mult_pipe #(.WIDTH(4), .TAG_W(8), .GRP(2)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_a(in_a[3:0]),
    .in_b(in_b[3:0]), .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov4),
    .out_ready(out_ready), .out_prod(p4), .out_tag(t4));

  booth_r4_mult_pipe #(.WIDTH(16), .TAG_W(8), .GRP(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .in_a(in_a[15:0]),
    .in_b(in_b[15:0]), .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov16),
    .out_ready(out_ready), .out_prod(p16), .out_tag(t16));

  booth_r4_mult_pipe #(.WIDTH(64), .TAG_W(8), .GRP(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .in_a(in_a),
    .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_prod(p64), .out_tag(t64));

  always_comb begin
    in_ready  = r64;
    out_valid = ov64;
    out_prod  = p64;
    out_tag   = t64;
    if (sel == 0) begin
      in_ready = r4; out_valid = ov4; out_prod = {120'd0, p4}; out_tag = t4;
    end else if (sel == 1) begin
      in_ready = r16; out_valid = ov16; out_prod = {96'd0, p16}; out_tag = t16;
    end
  end

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic [127:0] p;
    logic [7:0]   t;
  } exp_t;

  // Reference: extend each operand to an integer per signedness, multiply, keep 2w bits.
  function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                            input logic sgn, input int w);
    logic signed [129:0] m, ea, eb, p;
    m  = (130'sd1 <<< w) - 130'sd1;
    ea = $signed({66'd0, a}) & m;
    eb = $signed({66'd0, b}) & m;
    if (sgn && a[w-1]) ea = ea - (130'sd1 <<< w);
    if (sgn && b[w-1]) eb = eb - (130'sd1 <<< w);
    p = ea * eb;
    return p[127:0] & ((128'd1 << (2 * w)) - 128'd1);
  endfunction

  // Random operand of width w, biased towards the range extremes.
  function automatic logic [63:0] rand_op(input int w);
    logic [63:0] m, v;
    m = (64'd1 << w) - 64'd1;
    case ($urandom_range(7))
      0:       v = 64'd1 << (w - 1);
      1:       v = m;
      2:       v = '0;
      3:       v = m >> 1;
      default: v = {$urandom, $urandom} & m;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_tag, out_prod, in_ready} !== {1'b0, 8'd0, 128'd0, 1'b1})
      $display("FAIL reset_state: got v=%b tag=%h prod=%h rdy=%b want 0/0/0/1",
               out_valid, out_tag, out_prod, in_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_corners();
    logic [63:0]  ta [6];
    logic [63:0]  tbv [6];
    logic         ts [6];
    logic [127:0] te [6];
    ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[0] = 64'hFFFF_FFFF_FFFF_FFFF; ts[0] = 1'b1;
    te[0] = 128'd1;
    ta[1] = 64'h8000_0000_0000_0000; tbv[1] = 64'h8000_0000_0000_0000; ts[1] = 1'b1;
    te[1] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tbv[2] = 64'hFFFF_FFFF_FFFF_FFFF; ts[2] = 1'b0;
    te[2] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    ta[3] = 64'h8000_0000_0000_0000; tbv[3] = 64'h7FFF_FFFF_FFFF_FFFF; ts[3] = 1'b1;
    te[3] = 128'hC000_0000_0000_0000_8000_0000_0000_0000;
    ta[4] = 64'd3; tbv[4] = 64'hFFFF_FFFF_FFFF_FFFF; ts[4] = 1'b1;
    te[4] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD;
    ta[5] = 64'd3; tbv[5] = 64'hFFFF_FFFF_FFFF_FFFF; ts[5] = 1'b0;
    te[5] = 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFD;
    sel = 2;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = ta[i]; in_b = tbv[i]; in_signed = ts[i]; in_tag = 8'(160 + i);
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL corner_in_ready[%0d]: got %b want 1", i, in_ready);
      else passed++;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL corner_early[%0d]: got valid %b want 0", i, out_valid);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({out_valid, out_tag, out_prod} !== {1'b1, 8'(160 + i), te[i]})
        $display("FAIL corner_prod[%0d]: got v=%b tag=%h prod=%h want 1 %h %h",
                 i, out_valid, out_tag, out_prod, 8'(160 + i), te[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e [8];
    sel = 2;
    out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c < 8); in_a = rand_op(64); in_b = rand_op(64);
      in_signed = 1'($urandom); in_tag = 8'(c);
      if (c < 8) e[c] = ref_prod(in_a, in_b, in_signed, 64);
      @(posedge clk); #1;
      total++;
      if (c < 2) begin
        if (out_valid !== 1'b0) $display("FAIL b2b_lead[%0d]: got valid %b want 0", c, out_valid);
        else passed++;
      end else begin
        if ({out_valid, out_tag, out_prod} !== {1'b1, 8'(c - 2), e[c-2]})
          $display("FAIL b2b_out[%0d]: got v=%b tag=%h prod=%h want 1 %h %h",
                   c, out_valid, out_tag, out_prod, 8'(c - 2), e[c-2]);
        else passed++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_tail: got valid %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [127:0] e [4];
    sel = 2;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = rand_op(64); in_b = rand_op(64);
      in_signed = 1'($urandom); in_tag = 8'(16 + k);
      e[k] = ref_prod(in_a, in_b, in_signed, 64);
      @(posedge clk);
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) begin
        in_a = rand_op(64); in_b = rand_op(64); in_signed = 1'($urandom); in_tag = 8'd19;
        e[3] = ref_prod(in_a, in_b, in_signed, 64);
      end
      #1;
      total++;
      if ({in_ready, out_valid, out_tag, out_prod} !== {1'b0, 1'b1, 8'd16, e[0]})
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b tag=%h prod=%h want 0 1 10 %h",
                 s, in_ready, out_valid, out_tag, out_prod, e[0]);
      else passed++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release: got rdy %b want 1", in_ready);
    else passed++;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if (r < 3) begin
        if ({out_valid, out_tag, out_prod} !== {1'b1, 8'(17 + r), e[r+1]})
          $display("FAIL stall_drain[%0d]: got v=%b tag=%h prod=%h want 1 %h %h",
                   r, out_valid, out_tag, out_prod, 8'(17 + r), e[r+1]);
        else passed++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL stall_dup: got valid %b want 0", out_valid);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ec;
    sel = 2;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = rand_op(64); in_b = rand_op(64); in_tag = 8'(48 + k);
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1) $display("FAIL rst_pre: got valid %b want 1", out_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_prod} !== {1'b0, 128'd0})
      $display("FAIL rst_async: got v=%b prod=%h want 0 0", out_valid, out_prod);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_ghost[%0d]: got valid %b want 0", c, out_valid);
      else passed++;
    end
    @(negedge clk);
    in_valid = 1'b1; in_a = rand_op(64); in_b = rand_op(64);
    in_signed = 1'($urandom); in_tag = 8'd99;
    ec = ref_prod(in_a, in_b, in_signed, 64);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_tag, out_prod} !== {1'b1, 8'd99, ec})
      $display("FAIL rst_next: got v=%b tag=%h prod=%h want 1 63 %h", out_valid, out_tag, out_prod, ec);
    else passed++;
  endtask

  task automatic test_random(input int s, input int w, input int nops);
    exp_t q[$];
    exp_t h;
    int   sent = 0;
    int   cyc = 0;
    sel = s;
    while ((sent < nops || q.size() > 0) && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < nops) && ($urandom_range(9) < 7);
      in_a      = rand_op(w);
      in_b      = rand_op(w);
      in_signed = 1'($urandom);
      in_tag    = 8'(sent);
      out_ready = ($urandom_range(9) < 7);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          $display("FAIL rand_w%0d_extra: got tag=%h prod=%h want no output", w, out_tag, out_prod);
        end else begin
          h = q.pop_front();
          if ({out_tag, out_prod} !== {h.t, h.p})
            $display("FAIL rand_w%0d: got tag=%h prod=%h want %h %h", w, out_tag, out_prod, h.t, h.p);
          else passed++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{p: ref_prod(in_a, in_b, in_signed, w), t: in_tag});
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 25000) begin
      total++;
      $display("FAIL rand_w%0d_timeout: got %0d sent %0d pending want all done", w, sent, q.size());
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random(0, 4, 3334);
    test_random(1, 16, 3333);
    test_random(2, 64, 3333);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
